// File: rtl/tmp_meas_sched.sv
// Measurement scheduler for the temperature-sensor switched-capacitor core.
// Define TMP_SCHED_AVG_EN to publish the average of four consecutive windows per result.
module tmp_meas_sched #(
  parameter int CNT_W  = 10,
  parameter int SETTLE = 16,
  parameter int PER_W  = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             cont_en,
  input  logic [PER_W-1:0] period,
  input  logic [CNT_W-1:0] win_len,
  input  logic             cmp,
  output logic             core_rst,
  output logic             busy,
  output logic [CNT_W-1:0] result,
  output logic             result_valid,
  input  logic             result_ready,
  output logic             overrun
);

  localparam int SET_W = $clog2(SETTLE + 1);
  localparam int TMR_A = (PER_W > CNT_W) ? PER_W : CNT_W;
  localparam int TMR_W = (TMR_A > SET_W) ? TMR_A : SET_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_MEASURE,
    S_DONE,
    S_GAP
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic             r_cmp_meta;
  logic             r_cmp_s;

  logic [TMR_W-1:0] r_tmr;
  logic [TMR_W-1:0] w_tmr_end;
  logic             w_tmr_done;

  logic [CNT_W-1:0] r_win_q;
  logic [CNT_W-1:0] r_ones;
  logic [CNT_W-1:0] w_ones_nxt;
  logic [CNT_W-1:0] w_pub;

  logic             r_core_rst;
  logic             r_busy;
  logic [CNT_W-1:0] r_result;
  logic             r_valid;
  logic             r_overrun;

  logic             w_load_win;
  logic             w_publish;
  logic             w_xfer;
  logic             w_last_win;
  logic             w_active_nxt;

  // cmp is asynchronous to clk; only the second flop's output is ever used.
  // NOTE: sequential state is written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cmp_meta <= 1'b0;
      r_cmp_s    <= 1'b0;
    end else begin
      r_cmp_meta <= cmp;
      r_cmp_s    <= r_cmp_meta;
    end
  end

  // Last timer value of the current timed state; >= keeps GAP safe if period shrinks mid-gap.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    w_tmr_end = '0;
    case (r_state)
      S_SETTLE:  w_tmr_end = TMR_W'(SETTLE - 1);
      S_MEASURE: w_tmr_end = TMR_W'(r_win_q) - TMR_W'(1);
      S_GAP:     w_tmr_end = (period == '0) ? '0 : TMR_W'(period) - TMR_W'(1);
      default:   w_tmr_end = '0;
    endcase
  end

  assign w_tmr_done = (r_tmr >= w_tmr_end);

`ifdef TMP_SCHED_AVG_EN
  localparam int ACC_W = CNT_W + 2;

  logic [1:0]       r_win_idx;
  logic [ACC_W-1:0] r_acc;

  assign w_last_win = (r_win_idx == 2'd3);

  // The fourth window's count is folded in on its last MEASURE cycle, so DONE sees the full sum.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_win_idx <= 2'd0;
      r_acc     <= '0;
    end else if (r_state == S_IDLE || r_state == S_DONE) begin
      r_win_idx <= 2'd0;
      r_acc     <= '0;
    end else if (r_state == S_MEASURE && w_tmr_done) begin
      r_win_idx <= r_win_idx + 2'd1;
      r_acc     <= r_acc + ACC_W'(w_ones_nxt);
    end
  end

  assign w_pub = r_acc[ACC_W-1:2];
`else
  assign w_last_win = 1'b1;
  assign w_pub      = r_ones;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (start || cont_en) w_state_nxt = S_SETTLE;
      S_SETTLE:  if (w_tmr_done) w_state_nxt = S_MEASURE;
      S_MEASURE: if (w_tmr_done) w_state_nxt = w_last_win ? S_DONE : S_SETTLE;
      S_DONE:    w_state_nxt = cont_en ? S_GAP : S_IDLE;
      S_GAP: begin
        if (!cont_en)        w_state_nxt = S_IDLE;
        else if (w_tmr_done) w_state_nxt = S_SETTLE;
      end
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  assign w_load_win   = (r_state == S_IDLE || r_state == S_GAP) && (w_state_nxt == S_SETTLE);
  assign w_publish    = (r_state == S_DONE);
  assign w_xfer       = r_valid && result_ready;
  assign w_active_nxt = (w_state_nxt == S_SETTLE) || (w_state_nxt == S_MEASURE);
  assign w_ones_nxt   = (r_cmp_s && (r_ones != '1)) ? r_ones + CNT_W'(1) : r_ones;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_tmr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_state_nxt != r_state)
        r_tmr <= '0;
      else if (r_state == S_SETTLE || r_state == S_MEASURE || r_state == S_GAP)
        r_tmr <= r_tmr + TMR_W'(1);
    end
  end

  // A zero window length is promoted to one cycle at latch time.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_win_q <= '0;
    end else if (w_load_win) begin
      r_win_q <= (win_len == '0) ? CNT_W'(1) : win_len;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ones <= '0;
    end else if (r_state == S_SETTLE) begin
      r_ones <= '0;
    end else if (r_state == S_MEASURE) begin
      r_ones <= w_ones_nxt;
    end
  end

  // core_rst drives another block's reset, so it comes straight from a flop, never from decode.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_core_rst <= 1'b1;
      r_busy     <= 1'b0;
    end else begin
      r_core_rst <= !w_active_nxt;
      r_busy     <= w_active_nxt;
    end
  end

  // A result in DONE either replaces an accepted/absent one or is dropped and flagged.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_result  <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (w_xfer)
        r_overrun <= 1'b0;
      if (w_publish) begin
        if (!r_valid || result_ready) begin
          r_result <= w_pub;
          r_valid  <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (w_xfer) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign core_rst     = r_core_rst;
  assign busy         = r_busy;
  assign result       = r_result;
  assign result_valid = r_valid;
  assign overrun      = r_overrun;

  a_result_stable: assert property (@(posedge clk) disable iff (!reset_n)
    (r_valid && !result_ready) |=> $stable(r_result));
  a_overrun_has_valid: assert property (@(posedge clk) disable iff (!reset_n)
    r_overrun |-> r_valid);
  a_rst_vs_busy: assert property (@(posedge clk) disable iff (!reset_n)
    core_rst == !busy);

endmodule

// File: doc/tmp_meas_sched.md
# tmp_meas_sched

Measurement scheduler for the temperature-sensor switched-capacitor core. It holds the core in reset between conversions, releases it on request or on a periodic timer, and blanks the settling interval. It then counts comparator-high cycles over a programmable window and presents the count as a result with a valid/ready handshake. It sits between the register/bus side and the sensor phase sequencer, and drives that sequencer's active-high reset.

## Interface
- `CNT_W`, 10: width of window length, ones counter and result.
- `SETTLE`, 16: number of blanking cycles after core release, ≥1.
- `PER_W`, 16: width of the periodic-mode gap counter.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `reset_n`  in  1  reset, asynchronous and active-low.
- `start`  in  1  single-shot request; level sampled in IDLE.
- `cont_en`  in  1  continuous (periodic) mode enable.
- `period`  in  PER_W  gap cycles with core held in reset between conversions in continuous mode.
- `win_len`  in  CNT_W  measurement window in cycles; sampled on leaving IDLE/GAP; 0 is treated as 1.
- `cmp`  in  1  comparator output from analog core; asynchronous to `clk`.
- `core_rst`  out  1  active-high reset to the sensor phase sequencer.
- `busy`  out  1  high in SETTLE and MEASURE.
- `result`  out  CNT_W  count of comparator-high cycles in the last window.
- `result_valid`  out  1  result available.
- `result_ready`  in  1  consumer accepts result.
- `overrun`  out  1  sticky: a completed result was dropped.

## Operation
- `cmp` passes through a 2-flop synchronizer (`cmp_s`). Only `cmp_s` is used.
- States:
  - IDLE: `core_rst`=1. Moves to SETTLE when `start` or `cont_en` is high. `win_len` is latched into `win_q` at this transition.
  - SETTLE: `core_rst`=0. Runs for `SETTLE` cycles, then moves to MEASURE. The ones counter is cleared on entry.
  - MEASURE: `core_rst`=0. Runs for `win_q` cycles. The ones counter increments on each cycle where `cmp_s`=1. It saturates at 2^CNT_W−1, which is only reachable when `win_q`=2^CNT_W−1.
  - DONE: one cycle. `core_rst`=1. Publishes the result, then goes to GAP if `cont_en`=1, else IDLE.
  - GAP: `core_rst`=1. Counts `period` cycles, then moves to SETTLE and re-latches `win_len`. `period`=0 means GAP lasts 1 cycle.
- Deasserting `cont_en` during GAP goes to IDLE on the next cycle. Deasserting it during SETTLE or MEASURE lets the current conversion finish, then DONE goes to IDLE.
- Publishing in DONE:
  - If `result_valid`=0, or `result_ready`=1 in that same cycle: load `result`, set `result_valid`.
  - Otherwise: keep the old `result`, drop the new one, set `overrun`.
- Handshake: the transfer happens on a cycle where `result_valid` and `result_ready` are both 1. `result_valid` clears next cycle unless DONE reloads it in that same cycle. `result` is stable while valid and not accepted.
- `overrun` clears on the first accepted transfer.

## Timing
- Reset values: state IDLE, `core_rst`=1, `busy`=0, `result`=0, `result_valid`=0, `overrun`=0, all counters 0, synchronizer 0.
- Asserting `reset_n` low mid-conversion aborts immediately and asynchronously, with `core_rst`=1. No result is produced.
- `start` high at edge N: state is SETTLE and `core_rst`=0 from N+1.
- MEASURE occupies cycles N+1+SETTLE through N+SETTLE+win_q. DONE is the next cycle. `result_valid` is high from N+SETTLE+win_q+2.
- Start-to-valid latency is SETTLE+win_q+2 cycles. The `cmp` pin-to-count latency is 2 cycles.
- Continuous period between successive DONE cycles is max(period,1)+SETTLE+win_q+1 cycles.

## Configuration
- `TMP_SCHED_AVG_EN` defined:
  - Each published result is the average of 4 consecutive windows.
  - An internal (CNT_W+2)-bit accumulator adds 4 window counts. The core stays released between the 4 windows: each window passes through SETTLE again, but there is no GAP.
  - Publishes `acc>>2` (truncating) after the 4th window.
  - A window counter of 2 bits resets on IDLE.
- Not defined: one window per result, as described above; no accumulator logic is synthesized.

## Test plan
- Single shot, SETTLE=16, `win_len`=100, `cmp` high for 37 cycles of the window → `result`=37, `result_valid` high exactly 118 cycles after the `start` edge, `core_rst`=1 again afterwards.
- Continuous mode, `period`=50, `win_len`=20, `result_ready` tied 1 → valid pulses every 87 cycles; `core_rst` high for 51 cycles between conversions.
- Continuous mode with `result_ready`=0 → second DONE sets `overrun`, `result` holds the first value; asserting `result_ready` for one cycle clears `result_valid` and `overrun`.
- `win_len`=0 with `cmp`=1 constantly → `result`=1; `win_len`=1023 with `cmp`=1 → `result`=1023 with no wrap.
- `reset_n` pulsed low in the middle of MEASURE → `core_rst`=1 immediately, no `result_valid`, state IDLE; the next `start` gives a correct fresh count.
- With `TMP_SCHED_AVG_EN`, window counts 10, 11, 12, 14 → `result`=11, one valid per 4 windows.
